// File: rtl/vga_color_sequencer_if.sv
// Bundles the button/vblank inputs and the colour/mode/status outputs of
// vga_color_sequencer. The slave modport is the sequencer's view.
interface vga_color_sequencer_if #(
  parameter int FRAME_W = 16
);
  logic               button;
  logic               vga_vb;
  logic [7:0]         color;
  logic [1:0]         mode;
  logic               color_update;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output button, vga_vb,
    input  color, mode, color_update, frame_cnt
  );

  modport slave (
    input  button, vga_vb,
    output color, mode, color_update, frame_cnt
  );
endinterface

// File: rtl/vga_color_sequencer.sv
// Debounces a push button and steps the VGA colour through SOLID/CYCLE/BLINK
// modes, changing the colour only on the rising edge of vertical blank.
module vga_color_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned FRAMES_PER_STEP = 30,
  parameter logic [7:0]  SOLID_COLOR     = 8'hE0,
  parameter logic [7:0]  STEP            = 8'h01,
  parameter int          FRAME_W         = 16
) (
  input logic                    clk_sys,
  input logic                    reset,
  vga_color_sequencer_if.slave   bus
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [DBW-1:0] DEB_MAX  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0]  STEP_MAX = SW'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_CYCLE = 2'd1,
    MODE_BLINK = 2'd2
  } mode_e;

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               deb_level_q, deb_level_d;
  logic [DBW-1:0]     deb_cnt_q, deb_cnt_d;
  logic               press_q, press_d;
  logic               pending_q, pending_d;
  logic               vb_q, vb_d;
  mode_e              mode_q, mode_d;
  logic [7:0]         color_q, color_d;
  logic               phase_q, phase_d;
  logic [SW-1:0]      step_cnt_q, step_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               color_update_q, color_update_d;

  logic btn_s;
  logic tick_s;
  logic advance_s;

  // Next-state logic: synchronizer, debounce, frame tick and mode/colour sequencing
  always_comb begin
    sync1_d        = bus.button;
    sync2_d        = sync1_q;
    deb_level_d    = deb_level_q;
    deb_cnt_d      = deb_cnt_q;
    press_d        = 1'b0;
    pending_d      = pending_q;
    vb_d           = bus.vga_vb;
    mode_d         = mode_q;
    color_d        = color_q;
    phase_d        = phase_q;
    step_cnt_d     = step_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    color_update_d = 1'b0;

    btn_s     = sync2_q;
    tick_s    = bus.vga_vb & ~vb_q;
    advance_s = pending_q | press_q;

    if (btn_s == deb_level_q) begin
      deb_cnt_d = {DBW{1'b0}};
    end else if (deb_cnt_q == DEB_MAX) begin
      deb_level_d = btn_s;
      deb_cnt_d   = {DBW{1'b0}};
      press_d     = btn_s;
    end else begin
      deb_cnt_d = deb_cnt_q + DBW'(1);
    end

    // A press landing on the tick cycle is consumed by that tick, not left pending.
    if (tick_s) begin
      pending_d = 1'b0;
    end else if (press_q) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    if (tick_s && advance_s) begin
      frame_cnt_d    = frame_cnt_q + FRAME_W'(1);
      color_update_d = 1'b1;
      step_cnt_d     = {SW{1'b0}};
      phase_d        = 1'b1;
      case (mode_q)
        MODE_SOLID: begin
          mode_d  = MODE_CYCLE;
          color_d = 8'h00;
        end
        MODE_CYCLE: begin
          mode_d  = MODE_BLINK;
          color_d = SOLID_COLOR;
        end
        MODE_BLINK: begin
          mode_d  = MODE_SOLID;
          color_d = SOLID_COLOR;
        end
        default: begin
          mode_d  = MODE_SOLID;
          color_d = SOLID_COLOR;
        end
      endcase
    end else if (tick_s) begin
      frame_cnt_d    = frame_cnt_q + FRAME_W'(1);
      color_update_d = 1'b1;
      case (mode_q)
        MODE_SOLID: begin
          color_d = SOLID_COLOR;
        end
        MODE_CYCLE, MODE_BLINK: begin
          if (step_cnt_q == STEP_MAX) begin
            step_cnt_d = {SW{1'b0}};
            if (mode_q == MODE_CYCLE) begin
              color_d = color_q + STEP;
            end else begin
              phase_d = ~phase_q;
              color_d = phase_q ? 8'h00 : SOLID_COLOR;
            end
          end else begin
            step_cnt_d = step_cnt_q + SW'(1);
          end
        end
        default: begin
          mode_d  = MODE_SOLID;
          color_d = SOLID_COLOR;
        end
      endcase
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      deb_level_q    <= 1'b0;
      deb_cnt_q      <= {DBW{1'b0}};
      press_q        <= 1'b0;
      pending_q      <= 1'b0;
      vb_q           <= 1'b0;
      mode_q         <= MODE_SOLID;
      color_q        <= SOLID_COLOR;
      phase_q        <= 1'b1;
      step_cnt_q     <= {SW{1'b0}};
      frame_cnt_q    <= {FRAME_W{1'b0}};
      color_update_q <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      deb_level_q    <= deb_level_d;
      deb_cnt_q      <= deb_cnt_d;
      press_q        <= press_d;
      pending_q      <= pending_d;
      vb_q           <= vb_d;
      mode_q         <= mode_d;
      color_q        <= color_d;
      phase_q        <= phase_d;
      step_cnt_q     <= step_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      color_update_q <= color_update_d;
    end
  end

  assign bus.color        = color_q;
  assign bus.mode         = mode_q;
  assign bus.color_update = color_update_q;
  assign bus.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_color_sequencer.sv
// Scoreboard bench for vga_color_sequencer: ticks push expected colour/mode/
// frame count; a monitor pops and compares on every color_update pulse.
module tb_vga_color_sequencer;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] color;
    logic [3:0] frame;
  } exp_t;

  logic clk_sys;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic [3:0] exp_frames;
  exp_t sb_q[$];

  logic [7:0] prev_color;
  logic [1:0] prev_mode;
  logic       prev_rst;

  vga_color_sequencer_if #(.FRAME_W(4)) bus ();

  vga_color_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .FRAMES_PER_STEP(2),
    .SOLID_COLOR(8'hE0),
    .STEP(8'h01),
    .FRAME_W(4)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .bus(bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_tick(input logic [1:0] m, input logic [7:0] c);
    exp_t e;
    exp_frames = exp_frames + 4'd1;
    e.mode  = m;
    e.color = c;
    e.frame = exp_frames;
    sb_q.push_back(e);
    @(posedge clk_sys); #1 bus.vga_vb = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 bus.vga_vb = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  task automatic press();
    bus.button = 1'b1;
    repeat (10) @(posedge clk_sys);
    #1 bus.button = 1'b0;
    repeat (10) @(posedge clk_sys);
    #1;
  endtask

  task automatic bounce();
    for (int i = 0; i < 5; i++) begin
      bus.button = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1 bus.button = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
    end
    repeat (10) @(posedge clk_sys);
    #1;
  endtask

  // Monitor: scoreboard pops on each update, colour/mode stability otherwise
  always @(negedge clk_sys) begin
    if (bus.color_update === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_update", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("tick_mode", 32'(bus.mode), 32'(e.mode));
        check("tick_color", 32'(bus.color), 32'(e.color));
        check("tick_frame_cnt", 32'(bus.frame_cnt), 32'(e.frame));
      end
    end else if (reset && prev_rst) begin
      check("color_stable", 32'(bus.color), 32'(prev_color));
      check("mode_stable", 32'(bus.mode), 32'(prev_mode));
    end
    prev_color <= bus.color;
    prev_mode  <= bus.mode;
    prev_rst   <= reset;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    exp_frames = 4'd0;
    reset      = 1'b0;
    bus.button = 1'b0;
    bus.vga_vb = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_color", 32'(bus.color), 32'h0E0);
    check("rst_mode", 32'(bus.mode), 32'd0);
    check("rst_update", 32'(bus.color_update), 32'd0);
    check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    @(posedge clk_sys); #1 reset = 1'b1;
    repeat (2) @(posedge clk_sys); #1;

    // Idle frames stay SOLID
    for (int i = 0; i < 3; i++) do_tick(2'd0, 8'hE0);

    // Bouncing button must not register a press
    bounce();
    do_tick(2'd0, 8'hE0);

    // Two presses in one frame give a single advance, applied only at the tick
    press();
    press();
    @(negedge clk_sys);
    check("mode_before_tick", 32'(bus.mode), 32'd0);
    do_tick(2'd1, 8'h00);
    do_tick(2'd1, 8'h00);
    do_tick(2'd1, 8'h01);
    do_tick(2'd1, 8'h01);
    do_tick(2'd1, 8'h02);

    // Into BLINK, then alternate every two frames, ending in the OFF phase
    press();
    do_tick(2'd2, 8'hE0);
    do_tick(2'd2, 8'hE0);
    do_tick(2'd2, 8'h00);
    do_tick(2'd2, 8'h00);
    do_tick(2'd2, 8'hE0);
    do_tick(2'd2, 8'hE0);
    do_tick(2'd2, 8'h00);

    // Reset during a debounce and in BLINK/OFF
    bus.button = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    bus.button = 1'b0;
    @(posedge clk_sys); #1 reset = 1'b1;
    exp_frames = 4'd0;
    @(negedge clk_sys);
    check("mid_rst_color", 32'(bus.color), 32'h0E0);
    check("mid_rst_mode", 32'(bus.mode), 32'd0);
    check("mid_rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    repeat (10) @(posedge clk_sys); #1;
    do_tick(2'd0, 8'hE0);

    // CYCLE wrap FF -> 00; frame_cnt wraps many times along the way
    press();
    do_tick(2'd1, 8'h00);
    for (int k = 1; k <= 512; k++) do_tick(2'd1, 8'(k / 2));

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk_sys);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
